// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA timing generator.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    typedef struct packed {
        vga_timing_t h;
        vga_timing_t v;
    } vga_mode_t;

    // Bundle of strobes that travel together through the delay line.
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vga_strobe_t;

    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
        v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
    };

    localparam int VGA_CNT_W = 10;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; every stage resets asynchronously to RST_VAL.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator with delayed sync/valid/start strobes.
// Define VGA_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is 0.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_640x480_60.h.active),
    parameter int H_FP     = int'(VGA_640x480_60.h.fp),
    parameter int H_SYNC   = int'(VGA_640x480_60.h.sync),
    parameter int H_BP     = int'(VGA_640x480_60.h.bp),
    parameter int V_ACTIVE = int'(VGA_640x480_60.v.active),
    parameter int V_FP     = int'(VGA_640x480_60.v.fp),
    parameter int V_SYNC   = int'(VGA_640x480_60.v.sync),
    parameter int V_BP     = int'(VGA_640x480_60.v.bp),
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = VGA_CNT_W,
    parameter int PIPE_LAT = 1,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               valid,
    output logic [CNT_W-1:0]   curr_col,
    output logic [CNT_W-1:0]   curr_row,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2**CNT_W) begin : g_err_htotal
        $error("vga_timing_core: H_TOTAL does not fit in CNT_W");
    end
    if (V_TOTAL > 2**CNT_W) begin : g_err_vtotal
        $error("vga_timing_core: V_TOTAL does not fit in CNT_W");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_err_lat
        $error("vga_timing_core: PIPE_LAT must be 1..8");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_width
        $error("vga_timing_core: porch and sync widths must be non-zero");
    end

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    vga_strobe_t      w_strobe;
    vga_strobe_t      w_strobe_d;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
            if (w_h_wrap) r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_strobe       = '0;
        w_strobe.valid = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        w_strobe.hs    = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
        w_strobe.vs    = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
        w_strobe.ls    = (r_h_cnt == '0);
        w_strobe.fs    = (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    // Stages reset to all-zero, i.e. every strobe inactive before polarity is applied.
    vga_delay_line #(
        .WIDTH   ($bits(vga_strobe_t)),
        .DEPTH   (PIPE_LAT),
        .RST_VAL ('0)
    ) u_strobe_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_strobe),
        .o_q (w_strobe_d)
    );

    assign HSYNC       = ~(w_strobe_d.hs ^ HS_POL);
    assign VSYNC       = ~(w_strobe_d.vs ^ VS_POL);
    assign valid       = w_strobe_d.valid;
    assign line_start  = w_strobe_d.ls;
    assign frame_start = w_strobe_d.fs;
    assign curr_col    = r_h_cnt;
    assign curr_row    = r_v_cnt;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Randomised reset/run episodes on a tiny timing mode, checked against a cycle-count model.
module tb_vga_timing_core;

    localparam int HA = 8, HFP = 1, HSW = 2, HBP = 1;
    localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
    localparam int LAT = 3;
    localparam int HPOL = 1;
    localparam int VPOL = 0;
    localparam int CW = 4;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          HSYNC, VSYNC, valid, line_start, frame_start;
    logic [CW-1:0] curr_col, curr_row;
    logic [FW-1:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    vga_timing_core #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL   (1'b1), .VS_POL (1'b0),
        .CNT_W    (CW), .PIPE_LAT (LAT), .FRAME_W (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .valid       (valid),
        .curr_col    (curr_col),
        .curr_row    (curr_row),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string where);
        check_val({where, " col"},   32'(curr_col), 0);
        check_val({where, " row"},   32'(curr_row), 0);
        check_val({where, " valid"}, 32'(valid), 0);
        check_val({where, " ls"},    32'(line_start), 0);
        check_val({where, " fs"},    32'(frame_start), 0);
        check_val({where, " hsync"}, 32'(HSYNC), 32'(1 - HPOL));
        check_val({where, " vsync"}, 32'(VSYNC), 32'(1 - VPOL));
        check_val({where, " frame"}, 32'(frame_cnt), 0);
    endtask

    // n = number of clock edges since reset release; strobes describe position n-LAT.
    task automatic check_cycle(input int n);
        int p, h, v, fexp;
        bit a, hs_on, vs_on, ls, fs;
        p = n - LAT;
        a = 0; hs_on = 0; vs_on = 0; ls = 0; fs = 0;
        if (p >= 0) begin
            h     = p % HT;
            v     = (p / HT) % VT;
            a     = (h < HA) && (v < VA);
            hs_on = (h >= HA + HFP) && (h < HA + HFP + HSW);
            vs_on = (v >= VA + VFP) && (v < VA + VFP + VSW);
            ls    = (h == 0);
            fs    = (h == 0) && (v == 0);
        end
`ifdef VGA_FRAME_CNT_EN
        fexp = (n / FT) % (1 << FW);
`else
        fexp = 0;
`endif
        check_val("col",   32'(curr_col), 32'(n % HT));
        check_val("row",   32'(curr_row), 32'((n / HT) % VT));
        check_val("valid", 32'(valid), 32'(a));
        check_val("ls",    32'(line_start), 32'(ls));
        check_val("fs",    32'(frame_start), 32'(fs));
        check_val("hsync", 32'(HSYNC), hs_on ? 32'(HPOL) : 32'(1 - HPOL));
        check_val("vsync", 32'(VSYNC), vs_on ? 32'(VPOL) : 32'(1 - VPOL));
        check_val("frame", 32'(frame_cnt), 32'(fexp));
    endtask

    initial begin
        int n, len, hold;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("por");

        for (int ep = 0; ep < 8; ep++) begin
            @(negedge clk) rst = 1'b0;
            n   = 0;
            len = (ep == 0) ? 6 * FT : int'($urandom_range(20, 250));
            repeat (len) begin
                @(posedge clk);
                n++;
                #1 check_cycle(n);
            end
            // Mid-cycle assertion: outputs must clear before the next edge.
            #2 rst = 1'b1;
            #1 check_reset_vals("async");
            hold = int'($urandom_range(1, 3));
            repeat (hold) begin
                @(posedge clk);
                #1 check_reset_vals("hold");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_core.md
# vga_timing_core

Parametrised VGA timing generator: successor to the fixed 640x480 `vga` block in the display top level. It produces horizontal/vertical counters for the pixel generator (`screen_gen`) and sync/valid strobes. The strobes are delayed by a configurable pipeline latency so they stay aligned with a multi-cycle pixel path. It also adds line/frame start pulses and polarity control. It sits between the PLL output clock and `screen_gen`/the VGA adapter pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync widths, in clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync widths, in lines
- `HS_POL`, 0 / `VS_POL`, 0: sync active level (0 = active-low)
- `CNT_W`, 10: counter width
- `PIPE_LAT`, 1: cycles from `curr_col/curr_row` to strobes; legal range 1..8
- `FRAME_W`, 8: frame counter width

Ports (clock and reset first):
- `clk` in 1: pixel clock from `mypll`
- `rst` in 1: asynchronous, active-high reset
- `HSYNC` out 1: horizontal sync, polarity set by `HS_POL`
- `VSYNC` out 1: vertical sync, polarity set by `VS_POL`
- `valid` out 1: pixel is in the active region (delayed)
- `curr_col` out CNT_W: horizontal counter (undelayed)
- `curr_row` out CNT_W: vertical counter (undelayed)
- `line_start` out 1: one-cycle pulse at column 0 of every line (delayed)
- `frame_start` out 1: one-cycle pulse at column 0, row 0 (delayed)
- `frame_cnt` out FRAME_W: completed-frame count

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 and 525.
- `h_cnt` increments every clock and wraps from H_TOTAL-1 to 0.
- `v_cnt` increments only when `h_cnt` wraps, and wraps from V_TOTAL-1 to 0.
- `curr_col`/`curr_row` are the counter registers themselves. They run over the full range, including blanking.
- Decode from the current counters:
  - active = (h<H_ACTIVE)&&(v<V_ACTIVE)
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (asserted for whole lines)
  - ls = (h==0)
  - fs = (h==0 && v==0)
- The decoded bits pass through a PIPE_LAT-stage register chain. `HSYNC` = hs_delayed XNOR HS_POL, same for `VSYNC`.
- Elaboration must fail (`$error`) if H_TOTAL or V_TOTAL exceeds 2**CNT_W, if PIPE_LAT is outside 1..8, or if any porch/sync width is 0.

## Timing
- Reset values:
  - counters 0
  - every delay stage holds inactive (`valid`=0, `line_start`=0, `frame_start`=0, HSYNC=!HS_POL, VSYNC=!VS_POL)
  - `frame_cnt`=0
- Reset does not generate a spurious `frame_start`. The first `frame_start` appears PIPE_LAT cycles after the first clock edge that samples `rst`=0 with counters at 0,0.
- Strobe latency: the strobe for counter value (h,v) appears exactly PIPE_LAT clocks after `curr_col`=h and `curr_row`=v.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The delay chain is flushed and no partial pulses follow.
- Simultaneous wrap (h=H_TOTAL-1, v=V_TOTAL-1): both counters return to 0 on the same edge, and `frame_cnt` increments on that same edge.
- `frame_cnt` wraps from 2**FRAME_W-1 to 0.

## Configuration
- `VGA_FRAME_CNT_EN` defined: `frame_cnt` counter is instantiated as described above.
- Not defined: `frame_cnt` is tied to 0 and no counter flops exist. The port list is unchanged.

## Structure
- Package `vga_pkg` holds:
  - the `vga_timing_t` struct (active/fp/sync/bp fields)
  - constant `VGA_640x480_60` holding the default values
  - the default `CNT_W`
- Sub-module `vga_delay_line`: parametrised width/depth shift register with an asynchronous-reset value parameter. One instance carries all five strobes.

## Test plan
- Defaults, release reset: HSYNC falls (low) first when `curr_col`=656 plus 1 cycle. It is low for 96 clocks, and the line period is 800 clocks.
- Defaults: VSYNC low exactly for rows 490-491 (1600 clocks, appearing 1 cycle late). `valid` is high for 640x480 = 307200 cycles per frame.
- PIPE_LAT=4, HS_POL=1: HSYNC rises 4 cycles after `curr_col`=656. `frame_start` rises 4 cycles after (0,0) and lasts one cycle.
- Tiny mode (H 8/1/2/1, V 4/1/1/1): H_TOTAL=12, V_TOTAL=7, `frame_start` every 84 cycles. With FRAME_W=2 and the macro defined, `frame_cnt` goes 1,2,3,0.
- Assert `rst` at `curr_col`=300, row 200 for 3 cycles: outputs go to reset values asynchronously. After release, counting restarts at 0,0 with no extra pulses.
- Macro undefined: `frame_cnt` stays 0 across 3 frames.
